// File: rtl/range_mon_pkg.sv
// Shared types and default range bounds for the range counter and its monitor.
// The counter block and the monitor must agree on LO/HI, so the defaults live here.
package range_mon_pkg;

    localparam int RANGE_LO_DEFAULT = 10;
    localparam int RANGE_HI_DEFAULT = 40;

    typedef enum logic [1:0] {
        EMPTY,
        SYNC,
        UP,
        DN
    } mon_state_e;

    typedef enum logic [3:0] {
        C_NONE,
        C_ERR,
        C_FIRST,
        C_WUP,
        C_WDN,
        C_UP,
        C_DN,
        C_HOLD,
        C_JUMP
    } step_class_e;

    typedef struct packed {
        logic step_up;
        logic step_dn;
        logic wrap_up;
        logic wrap_dn;
        logic hold;
        logic jump;
        logic reversal;
        logic range_err;
    } mon_pulse_t;

endpackage

// File: rtl/range_step_classify.sv
// Pure combinational decode of one observed counter step into a step class.
// Checks are ordered so that the first matching rule wins.
module range_step_classify
    import range_mon_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LO    = RANGE_LO_DEFAULT,
    parameter int HI    = RANGE_HI_DEFAULT
) (
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] cur,
    input  logic             has_prev,
    output step_class_e      step_class
);

    localparam logic [WIDTH-1:0] LO_V    = WIDTH'(LO);
    localparam logic [WIDTH-1:0] HI_V    = WIDTH'(HI);
    localparam logic [WIDTH:0]   ONE_EXT = (WIDTH + 1)'(1);

    logic [WIDTH:0] curExt;
    logic [WIDTH:0] prevPlus;
    logic [WIDTH:0] prevMinus;

    // One extra bit keeps prev+1 / prev-1 from aliasing at the ends of the bus.
    always_comb begin
        curExt    = {1'b0, cur};
        prevPlus  = {1'b0, prev} + ONE_EXT;
        prevMinus = {1'b0, prev} - ONE_EXT;
    end

    always_comb begin
        step_class = C_JUMP;
        if ((cur < LO_V) || (cur > HI_V)) begin
            step_class = C_ERR;
        end else if (!has_prev) begin
            step_class = C_FIRST;
        end else if ((prev == HI_V) && (cur == LO_V)) begin
            step_class = C_WUP;
        end else if ((prev == LO_V) && (cur == HI_V)) begin
            step_class = C_WDN;
        end else if (curExt == prevPlus) begin
            step_class = C_UP;
        end else if (curExt == prevMinus) begin
            step_class = C_DN;
        end else if (cur == prev) begin
            step_class = C_HOLD;
        end
    end

endmodule

// File: rtl/range_count_monitor.sv
// Observes a range up/down counter and reports direction, step events,
// range errors and a saturating wrap count, all from registered outputs.
module range_count_monitor
    import range_mon_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LO    = RANGE_LO_DEFAULT,
    parameter int HI    = RANGE_HI_DEFAULT,
    parameter int WCW   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count_in,
    input  logic             sample,
    output logic             dir,
    output logic             locked,
    output logic             step_up,
    output logic             step_dn,
    output logic             wrap_up,
    output logic             wrap_dn,
    output logic             hold,
    output logic             jump,
    output logic             reversal,
    output logic             range_err,
    output logic [WCW-1:0]   wrap_cnt
);

    localparam logic [WCW-1:0] WRAP_ONE = WCW'(1);

    mon_state_e       state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             dir_q, dir_d;
    logic             locked_q, locked_d;
    mon_pulse_t       pulse_q, pulse_d;
    logic [WCW-1:0]   wrap_cnt_q, wrap_cnt_d;
    step_class_e      stepClass;

    range_step_classify #(
        .WIDTH (WIDTH),
        .LO    (LO),
        .HI    (HI)
    ) u_classify (
        .prev       (prev_q),
        .cur        (count_in),
        .has_prev   (state_q != EMPTY),
        .step_class (stepClass)
    );

    // An out-of-range sample drops the reference but keeps prev untouched.
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        pulse_d    = '0;
        wrap_cnt_d = wrap_cnt_q;
        if (sample) begin
            case (stepClass)
                C_ERR: begin
                    pulse_d.range_err = 1'b1;
                    state_d           = EMPTY;
                end
                C_FIRST: begin
                    prev_d  = count_in;
                    state_d = SYNC;
                end
                C_WUP: begin
                    pulse_d.wrap_up = 1'b1;
                    prev_d          = count_in;
                    state_d         = UP;
                end
                C_WDN: begin
                    pulse_d.wrap_dn = 1'b1;
                    prev_d          = count_in;
                    state_d         = DN;
                end
                C_UP: begin
                    pulse_d.step_up = 1'b1;
                    prev_d          = count_in;
                    state_d         = UP;
                end
                C_DN: begin
                    pulse_d.step_dn = 1'b1;
                    prev_d          = count_in;
                    state_d         = DN;
                end
                C_HOLD: begin
                    pulse_d.hold = 1'b1;
                    prev_d       = count_in;
                end
                C_JUMP: begin
                    pulse_d.jump = 1'b1;
                    prev_d       = count_in;
                    state_d      = SYNC;
                end
                default: begin
                end
            endcase
        end
        pulse_d.reversal = ((state_q == UP) && (state_d == DN)) ||
                           ((state_q == DN) && (state_d == UP));
        if ((pulse_d.wrap_up || pulse_d.wrap_dn) && (wrap_cnt_q != '1)) begin
            wrap_cnt_d = wrap_cnt_q + WRAP_ONE;
        end
        dir_d    = (state_d == UP);
        locked_d = (state_d == UP) || (state_d == DN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            prev_q     <= '0;
            dir_q      <= 1'b0;
            locked_q   <= 1'b0;
            pulse_q    <= '0;
            wrap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            dir_q      <= dir_d;
            locked_q   <= locked_d;
            pulse_q    <= pulse_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign dir       = dir_q;
    assign locked    = locked_q;
    assign step_up   = pulse_q.step_up;
    assign step_dn   = pulse_q.step_dn;
    assign wrap_up   = pulse_q.wrap_up;
    assign wrap_dn   = pulse_q.wrap_dn;
    assign hold      = pulse_q.hold;
    assign jump      = pulse_q.jump;
    assign reversal  = pulse_q.reversal;
    assign range_err = pulse_q.range_err;
    assign wrap_cnt  = wrap_cnt_q;

endmodule
